muldiv_sequencer: RTL

- Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting beside the main ALU in the execute stage.
- The control unit decodes an M-extension R-type instruction (op 0110011, funct7 = 0000001) and raises start with funct3 and operands.
- The block runs a fixed-length shift-add or restoring-divide sequence and holds the pipeline via stall until the result is ready.
- Returns a single XLEN-bit result per instruction.

---
 rtl/muldiv_if.sv | 31 +++
 rtl/muldiv_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Execute-stage handshake between the control unit (master) and the iterative
// M-extension unit (slave), plus the unit's FSM state for observation.
interface muldiv_if #(
  parameter int XLEN = 32
);
  // start is a one-cycle request, taken only while the unit is idle or
  // finishing (IDLE/DONE). stall stays high from the request cycle until the
  // result is ready. done pulses for one cycle with result valid, and result
  // then holds until the next accepted start. flush cancels any operation and
  // wins over start.
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall;
  logic [1:0]      state;

  modport master (
    output start, funct3, src_a, src_b, flush,
    input  busy, done, result, stall, state
  );

  modport slave (
    input  start, funct3, src_a, src_b, flush,
    output busy, done, result, stall, state
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one
// bit per cycle over XLEN cycles, with divide-by-zero and overflow resolved at accept.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        op;
  logic              neg;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   result_q;

  logic            can_accept, accept, is_div, signed_a, signed_b;
  logic            sign_a, sign_b, div_zero, ovf, special, last;
  logic [XLEN-1:0] mag_a, mag_b, special_val;

  always_comb begin
    can_accept  = (state == S_IDLE) || (state == S_DONE);
    accept      = can_accept && bus.start && !bus.flush;
    is_div      = bus.funct3[2];
    signed_a    = (bus.funct3 != 3'd3) && (bus.funct3 != 3'd5) && (bus.funct3 != 3'd7);
    signed_b    = (bus.funct3 == 3'd0) || (bus.funct3 == 3'd1) ||
                  (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
    sign_a      = signed_a && bus.src_a[XLEN-1];
    sign_b      = signed_b && bus.src_b[XLEN-1];
    mag_a       = sign_a ? -bus.src_a : bus.src_a;
    mag_b       = sign_b ? -bus.src_b : bus.src_b;
    div_zero    = is_div && (bus.src_b == '0);
    ovf         = is_div && !bus.funct3[0] && (bus.src_a == MIN_NEG) && (bus.src_b == '1);
    special     = div_zero || ovf;
    special_val = '0;
    if (div_zero)
      special_val = bus.funct3[1] ? bus.src_a : '1;
    else if (!bus.funct3[1])
      special_val = MIN_NEG;
    last        = (cnt == CW'(XLEN - 1));
  end

  // Multiply: upper half accumulates, multiplier shifts out of the lower half.
  // Divide: upper half is the partial remainder, lower half the dividend that
  // turns into the quotient as bits are shifted in.
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_diff, div_rem, quo, rem;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod;
  logic [XLEN-1:0]   final_val;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[XLEN-1:0] - opnd;
    div_rem   = div_ge ? div_diff : div_shift[XLEN-1:0];
    div_next  = {div_rem, acc[XLEN-2:0], div_ge};
    acc_next  = op[2] ? div_next : mul_next;
    prod      = neg ? -mul_next : mul_next;
    quo       = div_next[XLEN-1:0];
    rem       = div_next[2*XLEN-1:XLEN];
    if (op[2])
      final_val = op[1] ? (neg ? -rem : rem) : (neg ? -quo : quo);
    else
      final_val = (op == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.start) state_nx = special ? S_DONE : S_CALC;
        S_CALC:  if (last) state_nx = S_DONE;
        S_DONE:  state_nx = bus.start ? (special ? S_DONE : S_CALC) : S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy   = (state == S_CALC);
    bus.done   = (state == S_DONE);
    bus.stall  = (state == S_CALC) || (can_accept && bus.start);
    bus.result = result_q;
    bus.state  = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= '0;
      neg      <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
    end else if (accept) begin
      op   <= bus.funct3;
      // Remainder takes the dividend's sign; everything else takes a^b.
      neg  <= (bus.funct3[2] && bus.funct3[1]) ? sign_a : (sign_a ^ sign_b);
      cnt  <= '0;
      opnd <= is_div ? mag_b : mag_a;
      acc  <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
      if (special) result_q <= special_val;
    end else if (state == S_CALC) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (last) result_q <= final_val;
    end
  end
endmodule
